dac_sample_feeder: RTL and testbench
====================================

# dac_sample_feeder

- Paced sample source that sits directly upstream of the 16-bit SPI DAC transmitter.
- Buffers signed 12-bit samples from the DSP path in a small FIFO and emits one `idata`/`newTxData` pair per sample period.
- Honours the transmitter's `txBusy` handshake. The transmitter inverts bit 11, so two's-complement 0 becomes DAC midscale.
- Handles underflow by repeating the last sample, and records late periods.

## Interface
- `AW`, 3: FIFO address width; depth = 2^AW = 8.
- `DIV`, 200: sample period in `clk` cycles. Must be ≥ 190, since one SPI word takes ~176 cycles plus handshake.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  pacing enable. When 0: period counter held at 0 and no new ticks. An in-flight SPI word still completes.
- `sample_in`  in  12  signed two's-complement sample.
- `sample_valid`  in  1  `sample_in` valid.
- `sample_ready`  out  1  = !full. Push occurs when valid && ready.
- `idata`  out  12  sample to the SPI transmitter; registered and held between issues.
- `newTxData`  out  1  one-cycle start pulse to the SPI transmitter.
- `txBusy`  in  1  busy flag from the SPI transmitter.
- `late_cnt`  out  8  saturating count of periods that ticked while a tick was already pending.
- `fifo_level`  out  AW+1  current FIFO occupancy, 0..2^AW.

## Operation
- **Period counter:** 0..DIV-1, wraps. `tick` is asserted when the count is DIV-1 and `en`=1.
- **Tick pending:**
  - `tick` sets `tick_pend`; `tick_pend` clears when the FSM enters ISSUE.
  - If `tick` arrives while `tick_pend` is already 1: `late_cnt`++ (saturates at 255), and `tick_pend` stays 1. Ticks are never queued deeper than one.
- **FIFO:** synchronous, registered read, no bypass.
  - A push into an empty FIFO in the same cycle as a pop decision is not visible to that pop.
  - When full, `sample_ready`=0, so no push occurs.
- **FSM states:**
  - IDLE: if `tick_pend` && !`txBusy`, go to ISSUE; else stay.
  - ISSUE (1 cycle): if the FIFO is non-empty, pop and load `idata` and `last_smp`. If empty, load `idata` from `last_smp` (underflow). Pulse `newTxData`. Go to WAIT_BUSY.
  - WAIT_BUSY: go to WAIT_DONE when `txBusy`=1. If `txBusy` is not seen within 4 cycles, return to IDLE (the word is considered lost and is not retried).
  - WAIT_DONE: go to IDLE when `txBusy`=0.
- `newTxData` is never asserted outside ISSUE. This guarantees at most one request per transmitter word, even though the transmitter's `txBusy` lags its acceptance by 2 cycles.
- `en` falling mid-transaction does not abort the transaction. A `tick_pend` already set is still serviced.
- **Reset values:**
  - Outputs: `idata`=0, `newTxData`=0, `sample_ready`=1, `late_cnt`=0, `fifo_level`=0.
  - Internal: `last_smp`=0, FSM=IDLE, counter=0, `tick_pend`=0, FIFO pointers=0.
  - `reset_n` asserted mid-word drops `newTxData` immediately. The transmitter finishes or is reset on its own.

## Timing
- The tick is registered into `tick_pend` at edge T+1. IDLE→ISSUE happens at edge T+2, and `newTxData` is high for the cycle after T+2.
  - Tick-to-`newTxData` latency: 2 cycles.
- `idata` changes only on the edge that asserts `newTxData` and is stable for the whole SPI word.
- Issue-to-issue spacing is exactly DIV cycles when the FIFO never runs empty and no late ticks occur.
- `sample_ready` updates on the cycle after a push or pop; `fifo_level` is updated in the same cycle.

## Configuration
- `FEEDER_UNDERFLOW_CNT_EN`
  - Defined: adds output `underflow_cnt` (8 bits, reset 0). It increments, saturating at 255, on each ISSUE taken with an empty FIFO.
  - Undefined: the port and counter are absent. Underflow behaviour (repeat `last_smp`) is unchanged.

## Test plan
- Reset, `en`=1, DIV=200, no samples → first `newTxData` at cycle 201 with `idata`=0x000. Repeats every 200 cycles; `underflow_cnt` (if enabled) counts 1,2,3…
- Push 0x7FF, 0x800, 0x123 back-to-back, then run with `txBusy` modelled as going high 2 cycles after the pulse for 176 cycles → `idata` = 0x7FF, 0x800, 0x123 on three consecutive issues, then 0x123 repeats; `fifo_level` goes 3→0.
- Push 9 samples with no ticks → `sample_ready`=0 after the 8th, the 9th is not accepted, `fifo_level`=8.
- Hold `txBusy`=1 for 450 cycles → `late_cnt`=1, and exactly one `newTxData` occurs within 1 cycle after IDLE sees `txBusy`=0.
- Bench never raises `txBusy` → FSM returns to IDLE 4 cycles after the pulse, and the next pulse occurs on the next tick only.
- Assert `reset_n`=0 during WAIT_DONE → all outputs return to their reset values asynchronously, and the FIFO is empty.

Source files
------------

// File: rtl/dac_sample_feeder.sv
// Paced sample feeder for a 16-bit SPI DAC transmitter: FIFO-buffered signed 12-bit samples, one issue per DIV cycles.
// Define FEEDER_UNDERFLOW_CNT_EN to add the saturating underflow_cnt output.
module dac_sample_feeder #(
  parameter int AW  = 3,
  parameter int DIV = 200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        en,
  input  logic [11:0] sample_in,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic [11:0] idata,
  output logic        newTxData,
  input  logic        txBusy,
  output logic [7:0]  late_cnt,
  output logic [AW:0] fifo_level
`ifdef FEEDER_UNDERFLOW_CNT_EN
  ,
  output logic [7:0]  underflow_cnt
`endif
);
  localparam int            DEPTH    = 1 << AW;
  localparam int            CW       = $clog2(DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
  localparam logic [AW:0]   LVL_FULL = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state_q, state_d;

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick;
  logic          tick_pend_q, tick_pend_d;
  logic [7:0]    late_q, late_d;
  logic [1:0]    wb_cnt_q, wb_cnt_d;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q, level_d;
  logic [11:0]   mem [DEPTH];
  logic [11:0]   idata_q, last_smp_q;
  logic          push, pop, issue_go, fifo_empty;

  // Period counter and tick bookkeeping
  always_comb begin
    cnt_d = '0;
    if (en && cnt_q != CNT_LAST) cnt_d = cnt_q + CW'(1);
  end

  assign tick        = en && (cnt_q == CNT_LAST);
  assign issue_go    = (state_q == IDLE) && tick_pend_q && !txBusy;
  assign tick_pend_d = tick || (tick_pend_q && !issue_go);

  always_comb begin
    late_d = late_q;
    if (tick && tick_pend_q && !issue_go && late_q != 8'hFF) late_d = late_q + 8'd1;
  end

  // FIFO occupancy; a push landing with an empty-FIFO issue is not seen by that issue
  assign fifo_empty   = (level_q == '0);
  assign sample_ready = (level_q != LVL_FULL);
  assign push         = sample_valid && sample_ready;
  assign pop          = issue_go && !fifo_empty;

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + (AW + 1)'(1);
      2'b01:   level_d = level_q - (AW + 1)'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= sample_in;
  end

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d  = state_q;
    wb_cnt_d = wb_cnt_q;
    case (state_q)
      IDLE:      if (tick_pend_q && !txBusy) state_d = ISSUE;
      ISSUE: begin
        state_d  = WAIT_BUSY;
        wb_cnt_d = '0;
      end
      WAIT_BUSY: begin
        if (txBusy)                 state_d  = WAIT_DONE;
        else if (wb_cnt_q == 2'd3)  state_d  = IDLE;
        else                        wb_cnt_d = wb_cnt_q + 2'd1;
      end
      WAIT_DONE: if (!txBusy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    newTxData = 1'b0;
    if (state_q == ISSUE) newTxData = 1'b1;
  end

  // idata is loaded on the edge entering ISSUE so data and start pulse appear together
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      tick_pend_q <= 1'b0;
      late_q      <= '0;
      wb_cnt_q    <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      idata_q     <= '0;
      last_smp_q  <= '0;
    end else begin
      cnt_q       <= cnt_d;
      tick_pend_q <= tick_pend_d;
      late_q      <= late_d;
      wb_cnt_q    <= wb_cnt_d;
      level_q     <= level_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + AW'(1);
        idata_q    <= mem[rd_ptr_q];
        last_smp_q <= mem[rd_ptr_q];
      end else if (issue_go) begin
        idata_q    <= last_smp_q;
      end
    end
  end

`ifdef FEEDER_UNDERFLOW_CNT_EN
  logic [7:0] uf_q;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                                  uf_q <= '0;
    else if (issue_go && fifo_empty && uf_q != 8'hFF) uf_q <= uf_q + 8'd1;
  end
  assign underflow_cnt = uf_q;
`endif

  assign idata      = idata_q;
  assign late_cnt   = late_q;
  assign fifo_level = level_q;

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Directed/randomized bench for dac_sample_feeder with a queue-based reference model and a simple SPI transmitter model.
module tb_dac_sample_feeder;
  localparam int AW    = 3;
  localparam int DIV   = 200;
  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en;
  logic [11:0] sample_in;
  logic        sample_valid;
  logic        sample_ready;
  logic [11:0] idata;
  logic        newTxData;
  logic        txBusy;
  logic [7:0]  late_cnt;
  logic [AW:0] fifo_level;
`ifdef FEEDER_UNDERFLOW_CNT_EN
  logic [7:0]  underflow_cnt;
`endif

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc;
  int          phase;
  int          en_base;
  int          tx_mode;   // 0: normal transmitter, 1: busy held high, 2: busy never raised
  int          pulse_at;
  int          uf_exp;
  logic [11:0] last_exp;
  logic [11:0] q[$];

  always #5 clk = ~clk;

  dac_sample_feeder #(.AW(AW), .DIV(DIV)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .idata        (idata),
    .newTxData    (newTxData),
    .txBusy       (txBusy),
    .late_cnt     (late_cnt),
    .fifo_level   (fifo_level)
`ifdef FEEDER_UNDERFLOW_CNT_EN
    ,
    .underflow_cnt(underflow_cnt)
`endif
  );

  // Regular issue schedule: tick at base+DIV-1, issue two cycles later, then every DIV
  function automatic bit reg_pulse(input int c, input int base);
    return (c >= base + DIV + 1) && (((c - base - DIV - 1) % DIV) == 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h required %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input logic v, input logic [11:0] d);
    bit ep;
    int pre;
    int late_exp;
    sample_valid = v;
    sample_in    = d;
    @(posedge clk);
    #1;
    cyc++;
    if (phase == 2) ep = (cyc == 451) || (cyc == 601) || (cyc == 801);
    else            ep = reg_pulse(cyc, en_base);
    late_exp = (phase == 2 && cyc >= 400) ? 1 : 0;
    pre = q.size();
    if (ep) begin
      if (pre > 0)          last_exp = q.pop_front();
      else if (uf_exp < 255) uf_exp++;
    end
    if (v && pre < DEPTH) q.push_back(d);
    chk("newTxData", 32'(newTxData), 32'(ep));
    chk("idata", 32'(idata), 32'(last_exp));
    chk("fifo_level", 32'(fifo_level), 32'(q.size()));
    chk("sample_ready", 32'(sample_ready), 32'(q.size() < DEPTH));
    chk("late_cnt", 32'(late_cnt), 32'(late_exp));
`ifdef FEEDER_UNDERFLOW_CNT_EN
    chk("underflow_cnt", 32'(underflow_cnt), 32'(uf_exp));
`endif
    if (newTxData) begin
      pulse_at = cyc;
      $display("issue phase=%0d cyc=%0d idata=%03h level=%0d late=%0d", phase, cyc, idata, fifo_level, late_cnt);
    end
    case (tx_mode)
      0:       txBusy = (cyc >= pulse_at + 2) && (cyc < pulse_at + 178);
      1:       txBusy = 1'b1;
      default: txBusy = 1'b0;
    endcase
  endtask

  task automatic do_reset();
    reset_n      = 1'b0;
    en           = 1'b0;
    sample_valid = 1'b0;
    sample_in    = '0;
    txBusy       = 1'b0;
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    cyc      = 0;
    q.delete();
    last_exp = '0;
    uf_exp   = 0;
    pulse_at = -1000;
    tx_mode  = 0;
    en_base  = 1000000;
  endtask

  task automatic reset_outputs_check(input string tag);
    chk({tag, "_idata"}, 32'(idata), 32'h0);
    chk({tag, "_newTxData"}, 32'(newTxData), 32'h0);
    chk({tag, "_sample_ready"}, 32'(sample_ready), 32'h1);
    chk({tag, "_late_cnt"}, 32'(late_cnt), 32'h0);
    chk({tag, "_fifo_level"}, 32'(fifo_level), 32'h0);
`ifdef FEEDER_UNDERFLOW_CNT_EN
    chk({tag, "_underflow_cnt"}, 32'(underflow_cnt), 32'h0);
`endif
  endtask

  task automatic async_reset_check(input string tag);
    #3 reset_n = 1'b0;
    #1;
    reset_outputs_check(tag);
  endtask

  initial begin
    logic v;
    reset_n = 1'b0;

    // Reset values, then an empty FIFO issuing midscale every period
    do_reset();
    reset_outputs_check("por");
    phase = 1; en = 1'b1; en_base = 0;
    while (cyc < 699) step(1'b0, 12'h000);

    // Three back-to-back pushes issued in order, then the last one repeats
    step(1'b1, 12'h7FF);
    step(1'b1, 12'h800);
    step(1'b1, 12'h123);
    while (cyc < 1500) step(1'b0, 12'h000);

    // Random traffic: fast enough to fill the FIFO, then slow enough to drain it
    while (cyc < 2300) begin
      v = ($urandom_range(0, 39) == 0);
      step(v, 12'($urandom_range(0, 4095)));
    end
    while (cyc < 3550) begin
      v = ($urandom_range(0, 399) == 0);
      step(v, 12'($urandom_range(0, 4095)));
    end
    while (cyc < 3601) step(1'b0, 12'h000);
    async_reset_check("rst_in_issue");

    // txBusy held high: one late tick, single issue once busy drops, then no-handshake words
    do_reset();
    phase = 2; en = 1'b1; en_base = 0;
    tx_mode = 1; txBusy = 1'b1;
    while (cyc < 449) step(1'b0, 12'h000);
    tx_mode = 2;
    while (cyc < 900) step(1'b0, 12'h000);

    // Fill with pacing off: ninth sample rejected; then drain through the transmitter
    do_reset();
    phase = 3;
    repeat (9) step(1'b1, 12'($urandom_range(0, 4095)));
    en = 1'b1; en_base = cyc;
    while (cyc < 1849) step(1'b0, 12'h000);
    step(1'b1, 12'h5A5);
    step(1'b1, 12'hA5A);
    while (cyc < 1860) step(1'b0, 12'h000);
    async_reset_check("rst_in_wait_done");

    // After reset the FIFO is empty and the repeated sample is back to zero
    do_reset();
    phase = 4; en = 1'b1; en_base = 0;
    while (cyc < 205) step(1'b0, 12'h000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
